prf_freelist: RTL and testbench
===============================

// Module: prf_freelist
// PURPOSE
//  Physical-register free list for the 2-wide OoO core. Sits beside rename/dispatch, upstream of the ROB.
//  - Hands out up to 2 free PRF tags per cycle to newly renamed destinations.
//  - Takes back T_old tags from the ROB's 2-wide retire port.
//  - Rewinds its allocation pointer on ROB rollback and replays allocations for surviving instrs during ROB walk.
// PARAMETERS
//  PRF_NUM   64  physical registers (from common); PRF_WIDTH = $clog2(PRF_NUM)
//  ARF_NUM   32  architectural registers (from common); reset maps Ai->Pi
//  FL_NUM    PRF_NUM-ARF_NUM  FIFO depth (32); FL_WIDTH = $clog2(FL_NUM)
// PORTS
//  clk              in   1          core clock
//  reset_n          in   1          async active-low reset
//  alloc0_valid     in   1          dispatch slot0 needs a dest tag this cycle
//  alloc1_valid     in   1          dispatch slot1 needs a dest tag this cycle
//  alloc0_T         out  PRF_WIDTH  tag granted to the first requesting slot
//  alloc1_T         out  PRF_WIDTH  tag granted to the second requesting slot
//  fl_left          out  2          00 empty, 01 one free, 10 two or more
//  retire0_valid    in   1          ROB retire slot0 (ROB tail order)
//  retire0_is_wb    in   1          slot0 wrote a dest; free its T_old
//  retire0_fl_Told  in   PRF_WIDTH  tag to release, slot0
//  retire1_valid    in   1          ROB retire slot1
//  retire1_is_wb    in   1          slot1 wrote a dest; free its T_old
//  retire1_fl_Told  in   PRF_WIDTH  tag to release, slot1
//  rob_state        in   2          ROB FSM: rob_idle / rob_rollback / rob_walk
//  walk0_valid      in   1          ROB walk slot0 surviving wb instr
//  walk1_valid      in   1          ROB walk slot1 surviving wb instr
//  fl_err           out  1          sticky error flag; present only with FREELIST_CHECK_EN
// BEHAVIOUR
//  Storage
//  - fifo[FL_NUM] of PRF_WIDTH tags.
//  - head, commit_head, tail: FL_WIDTH+1 bits each; the MSB is the wrap bit.
//  - count = tail - head, range 0..FL_NUM.
//  Reset (async, reset_n=0)
//  - fifo[i] = ARF_NUM+i; head = 0; commit_head = 0; tail = {1'b1, 0} (full).
//  - Outputs: fl_left = 10, alloc0_T = 32, alloc1_T = 33, fl_err = 0.
//  - Reset asserted mid-walk/rollback discards all state; no residual ROB context.
//  Allocate (rob_state == rob_idle only)
//  - n_alloc = alloc0_valid + alloc1_valid.
//  - Requests are compacted: the first requesting slot gets fifo[head], the second gets fifo[head+1].
//  - When only slot1 requests, alloc1_T = fifo[head]; alloc0_T then also shows fifo[head] (don't care).
//  - Tags are combinational from registered state; head += n_alloc on the clock edge.
//  - Dispatch must keep n_alloc <= fl_left. Violating this is illegal: head is not clamped, fl_err is flagged.
//  - fl_left is derived from the registered count only. Tags released this cycle are not grantable until next cycle.
//  Release (any rob_state)
//  - n_rel = (retire0_valid & retire0_is_wb) + (retire1_valid & retire1_is_wb).
//  - Pushes compact at tail in slot order; tail += n_rel.
//  - commit_head += n_rel, since each retiring wb instr consumed exactly one tag in program order.
//  - Dispatch guarantees is_wb=0 for rd=x0, so P0..P31 reset mappings are never double-freed incorrectly.
//  - Alloc and release in the same cycle are independent; count' = count - n_alloc + n_rel.
//  Recovery
//  - rob_rollback (every cycle in this state): head <= commit_head (plus n_rel if a release fires the same cycle).
//    Alloc inputs are ignored. Rollback re-entered from walk restarts from commit_head.
//  - rob_walk: head += walk0_valid + walk1_valid. Replays the tags already held by surviving instrs, in ROB order.
//    Alloc inputs are ignored.
//  - rob_walk -> rob_idle: normal allocation resumes; no extra bubble in this block.
//  Boundaries
//  - Pointers wrap modulo FL_NUM with a toggling MSB.
//  - Empty when head == tail; full when the indices are equal and the MSBs differ.
//  - Push when full cannot occur in a legal run; fl_err is flagged.
// CONFIGURATION
//  FREELIST_CHECK_EN defined:
//  - Keeps a PRF_NUM-bit busy bitmap (reset: bits 0..ARF_NUM-1 set).
//  - Sets sticky fl_err on: allocating a busy tag; releasing a free tag; push when full; n_alloc > count.
//  - Adds SVA equivalents.
//  FREELIST_CHECK_EN undefined: no bitmap, fl_err port absent, zero extra logic.
// STRUCTURE
//  - common package: PRF_NUM, PRF_WIDTH, ARF_NUM, FL_NUM/FL_WIDTH localparams, rob_state encoding (rob_idle/rob_rollback/rob_walk).
//  - Single flat module, no sub-module; 2-bit popcounts are inline.
// TESTING
//  1 Reset -> fl_left=10, alloc0_T=32, alloc1_T=33; dual alloc for 16 cycles -> fl_left=00, tags 32..63 issued in order.
//  2 Drain to empty, then retire0 is_wb Told=5 -> next cycle fl_left=01, alloc0_T=5; slot1-only request gets 5.
//  3 Same-cycle dual alloc + dual release at count=2 -> count stays 2; released tags are not visible that cycle.
//  4 Alloc 6 tags (32..37), retire 2 wb, rollback -> head=commit_head (points at 34); walk with 3 valid over 2 cycles -> alloc0_T=37.
//  5 Rollback during walk -> head rewinds to commit_head again; walk replay then yields the correct next tag.
//  6 FREELIST_CHECK_EN: release Told=40 while 40 is already free -> fl_err=1 next cycle and stays set until reset.

Source files
------------

// File: rtl/prf_freelist_pkg.sv
// Shared constants and types for the physical-register free list.
// PRF_NUM/ARF_NUM size the register files. FL_NUM is the number of tags
// that can be free at once. Pointers carry one extra wrap bit above the index.
// rob_state_e is the ROB recovery FSM encoding that the free list observes.
package prf_freelist_pkg;

  localparam int PRF_NUM   = 64;
  localparam int PRF_WIDTH = $clog2(PRF_NUM);
  localparam int ARF_NUM   = 32;
  localparam int FL_NUM    = PRF_NUM - ARF_NUM;
  localparam int FL_WIDTH  = $clog2(FL_NUM);

  typedef logic [PRF_WIDTH-1:0] prf_tag_t;
  typedef logic [FL_WIDTH-1:0]  fl_idx_t;
  typedef logic [FL_WIDTH:0]    fl_ptr_t;   // MSB is the wrap bit

  typedef enum logic [1:0] {
    ROB_IDLE     = 2'd0,
    ROB_ROLLBACK = 2'd1,
    ROB_WALK     = 2'd2
  } rob_state_e;

  // 2-input popcount
  function automatic logic [1:0] pop2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/prf_freelist.sv
// prf_freelist: circular FIFO of free physical-register tags for a 2-wide core.
//   clk, reset_n          clock, async active-low reset
//   alloc{0,1}_valid      dispatch slots needing a destination tag (idle only)
//   alloc{0,1}_T          tags for the first / second requesting slot
//   fl_left               00 empty, 01 one free, 10 two or more (registered count)
//   retire{0,1}_*         ROB retire port; is_wb entries push their T_old back
//   rob_state             ROB_IDLE / ROB_ROLLBACK / ROB_WALK
//   walk{0,1}_valid       surviving wb instrs replayed during ROB walk
//   fl_err                sticky consistency error (FREELIST_CHECK_EN only)
// Macro FREELIST_CHECK_EN adds a busy bitmap, the sticky fl_err output
// and assertions. Without it the block has no checking logic.
// head is the speculative allocation pointer. commit_head trails it and moves
// only at retirement. Rollback snaps head back to commit_head, and walk
// advances head again over the tags still held by surviving instructions.
// FL_NUM must be a power of two so the index fields wrap naturally.
module prf_freelist
  import prf_freelist_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 alloc0_valid,
  input  logic                 alloc1_valid,
  output logic [PRF_WIDTH-1:0] alloc0_T,
  output logic [PRF_WIDTH-1:0] alloc1_T,
  output logic [1:0]           fl_left,
  input  logic                 retire0_valid,
  input  logic                 retire0_is_wb,
  input  logic [PRF_WIDTH-1:0] retire0_fl_Told,
  input  logic                 retire1_valid,
  input  logic                 retire1_is_wb,
  input  logic [PRF_WIDTH-1:0] retire1_fl_Told,
  input  logic [1:0]           rob_state,
  input  logic                 walk0_valid,
  input  logic                 walk1_valid
`ifdef FREELIST_CHECK_EN
  ,
  output logic                 fl_err
`endif
);

  prf_tag_t fifo_q [FL_NUM];
  fl_ptr_t  head_q, head_d, chead_q, chead_d, tail_q, tail_d;
  fl_ptr_t  count;
  fl_idx_t  head_idx, head1_idx, tail_idx, tail1_idx;
  logic     rel0, rel1;
  logic [1:0] n_alloc, n_rel, n_walk;

  assign head_idx  = head_q[FL_WIDTH-1:0];
  assign head1_idx = head_idx + fl_idx_t'(1);
  assign tail_idx  = tail_q[FL_WIDTH-1:0];
  assign tail1_idx = tail_idx + fl_idx_t'(1);
  assign count     = tail_q - head_q;

  assign rel0    = retire0_valid & retire0_is_wb;
  assign rel1    = retire1_valid & retire1_is_wb;
  assign n_rel   = pop2(rel0, rel1);
  assign n_alloc = pop2(alloc0_valid, alloc1_valid);
  assign n_walk  = pop2(walk0_valid, walk1_valid);

  // Grants come from registered state only; tags pushed this cycle are
  // not visible until the next cycle.
  assign fl_left  = (count == '0) ? 2'b00 : (count == fl_ptr_t'(1)) ? 2'b01 : 2'b10;
  assign alloc0_T = fifo_q[head_idx];
  // Requests are compacted: a lone slot1 request takes the head entry.
  assign alloc1_T = (alloc1_valid & ~alloc0_valid) ? fifo_q[head_idx] : fifo_q[head1_idx];

  always_comb begin
    chead_d = chead_q + fl_ptr_t'(n_rel);
    tail_d  = tail_q + fl_ptr_t'(n_rel);
    head_d  = head_q;
    case (rob_state)
      ROB_IDLE:     head_d = head_q + fl_ptr_t'(n_alloc);
      // Same-cycle retirements also advance the rewind target.
      ROB_ROLLBACK: head_d = chead_d;
      ROB_WALK:     head_d = head_q + fl_ptr_t'(n_walk);
      default:      head_d = head_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= fl_ptr_t'(FL_NUM);   // wrap bit set, index 0: full
      for (int i = 0; i < FL_NUM; i++) fifo_q[i] <= prf_tag_t'(ARF_NUM + i);
    end else begin
      head_q  <= head_d;
      chead_q <= chead_d;
      tail_q  <= tail_d;
      if (rel0) fifo_q[tail_idx] <= retire0_fl_Told;
      if (rel1) fifo_q[rel0 ? tail1_idx : tail_idx] <= retire1_fl_Told;
    end
  end

`ifdef FREELIST_CHECK_EN
  logic [PRF_NUM-1:0] busy_q, busy_d;
  logic               err_q, err_d;
  fl_ptr_t            rb_span;
  logic               ovf;

  // Entries in [new commit_head, head) belong to squashed instrs on rollback.
  assign rb_span = head_q - chead_d;
  assign ovf     = ({1'b0, count} + (FL_WIDTH+2)'(n_rel)) > (FL_WIDTH+2)'(FL_NUM);

  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (rob_state == ROB_ROLLBACK) begin
      for (int j = 0; j < FL_NUM; j++) begin
        if (fl_ptr_t'({1'b0, fl_idx_t'(fl_idx_t'(j) - chead_d[FL_WIDTH-1:0])}) < rb_span)
          busy_d[fifo_q[j]] = 1'b0;
      end
    end
    if (rel0) begin
      if (!busy_q[retire0_fl_Told]) err_d = 1'b1;
      busy_d[retire0_fl_Told] = 1'b0;
    end
    if (rel1) begin
      if (!busy_q[retire1_fl_Told] || (rel0 && retire0_fl_Told == retire1_fl_Told))
        err_d = 1'b1;
      busy_d[retire1_fl_Told] = 1'b0;
    end
    if (ovf) err_d = 1'b1;
    if (rob_state == ROB_IDLE) begin
      if (fl_ptr_t'(n_alloc) > count) begin
        err_d = 1'b1;
      end else begin
        if (n_alloc != 2'd0) begin
          if (busy_q[fifo_q[head_idx]]) err_d = 1'b1;
          busy_d[fifo_q[head_idx]] = 1'b1;
        end
        if (n_alloc == 2'd2) begin
          if (busy_q[fifo_q[head1_idx]]) err_d = 1'b1;
          busy_d[fifo_q[head1_idx]] = 1'b1;
        end
      end
    end
    // Walk re-marks the tags of surviving instrs as held.
    if (rob_state == ROB_WALK) begin
      if (n_walk != 2'd0) busy_d[fifo_q[head_idx]]  = 1'b1;
      if (n_walk == 2'd2) busy_d[fifo_q[head1_idx]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= {{(PRF_NUM-ARF_NUM){1'b0}}, {ARF_NUM{1'b1}}};
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign fl_err = err_q;

  a_no_overalloc: assert property (@(posedge clk) disable iff (!reset_n)
    (rob_state == ROB_IDLE) |-> (fl_ptr_t'(n_alloc) <= count))
    else $warning("prf_freelist: allocation beyond free count");
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !ovf)
    else $warning("prf_freelist: push into full list");
  a_rel0_busy: assert property (@(posedge clk) disable iff (!reset_n)
    rel0 |-> busy_q[retire0_fl_Told])
    else $warning("prf_freelist: slot0 released a free tag");
  a_rel1_busy: assert property (@(posedge clk) disable iff (!reset_n)
    rel1 |-> busy_q[retire1_fl_Told])
    else $warning("prf_freelist: slot1 released a free tag");
`endif

endmodule

// File: tb/tb_prf_freelist.sv
// Directed bench for prf_freelist. A queue model (free tags, plus the tags
// held by in-flight instrs) predicts outputs every cycle, and literal
// expectations pin the scenarios.
module tb_prf_freelist;
  import prf_freelist_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic alloc0_valid = 0, alloc1_valid = 0;
  logic [PRF_WIDTH-1:0] alloc0_T, alloc1_T;
  logic [1:0] fl_left;
  logic retire0_valid = 0, retire0_is_wb = 0, retire1_valid = 0, retire1_is_wb = 0;
  logic [PRF_WIDTH-1:0] retire0_fl_Told = '0, retire1_fl_Told = '0;
  logic [1:0] rob_state = ROB_IDLE;
  logic walk0_valid = 0, walk1_valid = 0;
`ifdef FREELIST_CHECK_EN
  logic fl_err;
  bit   err_exp;
`endif

  always #5 clk = ~clk;

  prf_freelist dut (
    .clk(clk), .reset_n(reset_n),
    .alloc0_valid(alloc0_valid), .alloc1_valid(alloc1_valid),
    .alloc0_T(alloc0_T), .alloc1_T(alloc1_T), .fl_left(fl_left),
    .retire0_valid(retire0_valid), .retire0_is_wb(retire0_is_wb), .retire0_fl_Told(retire0_fl_Told),
    .retire1_valid(retire1_valid), .retire1_is_wb(retire1_is_wb), .retire1_fl_Told(retire1_fl_Told),
    .rob_state(rob_state), .walk0_valid(walk0_valid), .walk1_valid(walk1_valid)
`ifdef FREELIST_CHECK_EN
    , .fl_err(fl_err)
`endif
  );

  int checks = 0, errors = 0;
  int freeq[$];   // free tags, oldest first
  int spec[$];    // tags held by in-flight (unretired) wb instrs, program order

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    freeq.delete();
    spec.delete();
    for (int i = 0; i < FL_NUM; i++) freeq.push_back(ARF_NUM + i);
`ifdef FREELIST_CHECK_EN
    err_exp = 0;
`endif
  endtask

  task automatic compare();
    int n = freeq.size();
    chk("fl_left", fl_left, (n == 0) ? 0 : (n == 1) ? 1 : 2);
    if (n >= 1) chk("alloc0_T", alloc0_T, freeq[0]);
    if (alloc1_valid && !alloc0_valid) begin
      if (n >= 1) chk("alloc1_T", alloc1_T, freeq[0]);
    end else if (n >= 2) begin
      chk("alloc1_T", alloc1_T, freeq[1]);
    end
`ifdef FREELIST_CHECK_EN
    chk("fl_err", fl_err, err_exp);
`endif
  endtask

  task automatic model_update();
    int nr = 0;
    if (rob_state == ROB_IDLE) begin
      if (alloc0_valid && freeq.size() > 0) spec.push_back(freeq.pop_front());
      if (alloc1_valid && freeq.size() > 0) spec.push_back(freeq.pop_front());
    end
    if (retire0_valid && retire0_is_wb) nr++;
    if (retire1_valid && retire1_is_wb) nr++;
    for (int k = 0; k < nr; k++) if (spec.size() > 0) void'(spec.pop_front());
    if (retire0_valid && retire0_is_wb) freeq.push_back(int'(retire0_fl_Told));
    if (retire1_valid && retire1_is_wb) freeq.push_back(int'(retire1_fl_Told));
    if (rob_state == ROB_ROLLBACK) begin
      while (spec.size() > 0) freeq.push_front(spec.pop_back());
    end
    if (rob_state == ROB_WALK) begin
      if (walk0_valid && freeq.size() > 0) spec.push_back(freeq.pop_front());
      if (walk1_valid && freeq.size() > 0) spec.push_back(freeq.pop_front());
    end
  endtask

  task automatic drive(input bit a0, input bit a1,
                       input bit r0v, input bit r0wb, input int t0,
                       input bit r1v, input bit r1wb, input int t1,
                       input logic [1:0] st, input bit w0, input bit w1);
    alloc0_valid = a0; alloc1_valid = a1;
    retire0_valid = r0v; retire0_is_wb = r0wb; retire0_fl_Told = PRF_WIDTH'(t0);
    retire1_valid = r1v; retire1_is_wb = r1wb; retire1_fl_Told = PRF_WIDTH'(t1);
    rob_state = st; walk0_valid = w0; walk1_valid = w1;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, ROB_IDLE, 0, 0);
  endtask

  // Compare on the falling edge, advance the model, cross the rising edge.
  task automatic tick();
    @(negedge clk);
    compare();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit a0, input bit a1,
                      input bit r0v, input bit r0wb, input int t0,
                      input bit r1v, input bit r1wb, input int t1,
                      input logic [1:0] st, input bit w0, input bit w1);
    drive(a0, a1, r0v, r0wb, t0, r1v, r1wb, t1, st, w0, w1);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();
    idle();

    // 1: reset values, then drain the list with dual allocation
    chk("rst_fl_left", fl_left, 2);
    chk("rst_alloc0_T", alloc0_T, 32);
    chk("rst_alloc1_T", alloc1_T, 33);
    for (int k = 0; k < 16; k++) begin
      drive(1, 1, 0, 0, 0, 0, 0, 0, ROB_IDLE, 0, 0);
      chk("t1_alloc0_T", alloc0_T, 32 + 2 * k);
      chk("t1_alloc1_T", alloc1_T, 33 + 2 * k);
      tick();
    end
    idle();
    chk("t1_empty", fl_left, 0);

    // 2: release into empty list, then slot1-only request
    step(0, 0, 1, 1, 5, 0, 0, 0, ROB_IDLE, 0, 0);
    idle();
    chk("t2_fl_left", fl_left, 1);
    chk("t2_alloc0_T", alloc0_T, 5);
    drive(0, 1, 0, 0, 0, 0, 0, 0, ROB_IDLE, 0, 0);
    chk("t2_alloc1_T", alloc1_T, 5);
    tick();
    idle();
    chk("t2_empty", fl_left, 0);

    // 3: count=2, dual alloc and dual release in the same cycle
    step(0, 0, 1, 1, 6, 1, 1, 7, ROB_IDLE, 0, 0);
    idle();
    chk("t3_fl_left", fl_left, 2);
    drive(1, 1, 1, 1, 8, 1, 1, 9, ROB_IDLE, 0, 0);
    chk("t3_same_a0", alloc0_T, 6);
    chk("t3_same_a1", alloc1_T, 7);
    tick();
    idle();
    chk("t3_count_kept", fl_left, 2);
    chk("t3_next_a0", alloc0_T, 8);
    chk("t3_next_a1", alloc1_T, 9);
    // retire without is_wb releases nothing
    step(0, 0, 1, 0, 20, 1, 0, 21, ROB_IDLE, 0, 0);
    idle();
    chk("t3_nowb_a0", alloc0_T, 8);

    // 4: allocate 32..37, retire 2, rollback, walk 3
    do_reset();
    for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 0, 0, 0, 0, ROB_IDLE, 0, 0);
    step(0, 0, 1, 1, 1, 1, 1, 2, ROB_IDLE, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, ROB_ROLLBACK, 0, 0);
    idle();
    chk("t4_rollback_a0", alloc0_T, 34);
    step(0, 0, 0, 0, 0, 0, 0, 0, ROB_WALK, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, ROB_WALK, 1, 0);
    idle();
    chk("t4_walk_a0", alloc0_T, 37);

    // 5: rollback during walk, with a retirement in the rollback cycle
    step(1, 1, 0, 0, 0, 0, 0, 0, ROB_IDLE, 0, 0);
    idle();
    chk("t5_alloc_a0", alloc0_T, 39);
    step(0, 0, 0, 0, 0, 0, 0, 0, ROB_ROLLBACK, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, ROB_WALK, 1, 1);
    idle();
    chk("t5_midwalk_a0", alloc0_T, 36);
    step(0, 0, 1, 1, 3, 0, 0, 0, ROB_ROLLBACK, 0, 0);
    idle();
    chk("t5_rerollback_a0", alloc0_T, 35);
    step(0, 0, 0, 0, 0, 0, 0, 0, ROB_WALK, 0, 1);
    idle();
    chk("t5_rewalk_a0", alloc0_T, 36);
    step(1, 0, 0, 0, 0, 0, 0, 0, ROB_IDLE, 0, 0);
    idle();
    chk("t5_resume_a0", alloc0_T, 37);

    // reset while the ROB is mid-walk discards everything
    drive(0, 0, 0, 0, 0, 0, 0, 0, ROB_WALK, 1, 1);
    do_reset();
    idle();
    chk("rst2_fl_left", fl_left, 2);
    chk("rst2_alloc0_T", alloc0_T, 32);
    chk("rst2_alloc1_T", alloc1_T, 33);

`ifdef FREELIST_CHECK_EN
    // 6: release of a tag that is already free sets a sticky error
    chk("t6_err_clear", fl_err, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, ROB_IDLE, 0, 0);
    step(0, 0, 1, 1, 40, 0, 0, 0, ROB_IDLE, 0, 0);
    err_exp = 1;
    idle();
    chk("t6_err_set", fl_err, 1);
    tick();
    tick();
    chk("t6_err_sticky", fl_err, 1);
    do_reset();
    idle();
    chk("t6_err_reset", fl_err, 0);
`endif

    step(0, 0, 0, 0, 0, 0, 0, 0, ROB_IDLE, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
